// File: rtl/regfile_bank_pkg.sv
// Shared types and helpers for the register bank: defaults, byte-lane merge and address qualification.
package regfile_bank_pkg;

    localparam int RF_WIDTH_DFLT = 32;
    localparam int RF_DEPTH_DFLT = 32;
    localparam int RF_MAX_WIDTH  = 256;
    localparam int RF_MAX_BE     = RF_MAX_WIDTH / 8;

    typedef logic [RF_MAX_WIDTH-1:0] rf_word_t;
    typedef logic [RF_MAX_BE-1:0]    rf_be_t;

    // Callers zero-extend into the max-width types and truncate the result back.
    function automatic rf_word_t byte_merge(rf_word_t old_w, rf_word_t new_w, rf_be_t be);
        rf_word_t merged;
        for (int i = 0; i < RF_MAX_BE; i++) begin
            merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic addr_valid(logic [31:0] addr, logic [31:0] depth, bit zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// Write/read/debug bus of the register bank; master drives addresses and write data.
interface regfile_bank_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [NB-1:0]    wbe;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic             wr_hit;

    modport master (
        output we, waddr, wdata, wbe, raddr_a, raddr_b, dbg_addr,
        input  rdata_a, rdata_b, dbg_data, wr_hit
    );

    modport slave (
        input  we, waddr, wdata, wbe, raddr_a, raddr_b, dbg_addr,
        output rdata_a, rdata_b, dbg_data, wr_hit
    );

endinterface

// File: rtl/regfile_bank_read_port.sv
// One combinational read port: address decode with zero/out-of-range masking and optional write bypass.
module regfile_read_port
    import regfile_bank_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DFLT,
    parameter int DEPTH    = RF_DEPTH_DFLT,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH),
    localparam int NB      = WIDTH / 8
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] i_mem,
    input  logic [AW-1:0]               i_raddr,
    input  logic                        i_wr_ok,
    input  logic [AW-1:0]               i_waddr,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic [NB-1:0]               i_wbe,
    output logic [WIDTH-1:0]            o_rdata
);

    logic [WIDTH-1:0] w_base;
    logic             w_fwd;

    always_comb begin
        w_base = '0;
        if (addr_valid(32'(i_raddr), 32'(DEPTH), ZERO_REG)) begin
            w_base = i_mem[i_raddr];
        end
        // i_wr_ok already qualifies waddr, so a match implies a valid read address.
        w_fwd   = BYPASS && i_wr_ok && (i_raddr == i_waddr);
        o_rdata = w_base;
        if (w_fwd) begin
            o_rdata = WIDTH'(byte_merge(RF_MAX_WIDTH'(w_base), RF_MAX_WIDTH'(i_wdata),
                                        RF_MAX_BE'(i_wbe)));
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// DEPTH x WIDTH register bank, one byte-masked write port, two bypassable reads and a debug read.
// Reads are combinational; wr_hit flags a bit-changing write one cycle after its edge.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DFLT,
    parameter int DEPTH    = RF_DEPTH_DFLT,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_bank_if.slave  bus
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic                        r_wr_hit;

    logic             w_wr_ok;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_merged;

    always_comb begin
        w_wr_ok = bus.we && addr_valid(32'(bus.waddr), 32'(DEPTH), ZERO_REG);
        w_old   = '0;
        if (w_wr_ok) begin
            w_old = r_mem[bus.waddr];
        end
        w_merged = WIDTH'(byte_merge(RF_MAX_WIDTH'(w_old), RF_MAX_WIDTH'(bus.wdata),
                                     RF_MAX_BE'(bus.wbe)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_hit <= 1'b0;
        end else begin
            r_wr_hit <= w_wr_ok && (w_merged != w_old);
            if (w_wr_ok) begin
                r_mem[bus.waddr] <= w_merged;
            end
        end
    end

    assign bus.wr_hit = r_wr_hit;

    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd_a (
        .i_mem(r_mem), .i_raddr(bus.raddr_a), .i_wr_ok(w_wr_ok), .i_waddr(bus.waddr),
        .i_wdata(bus.wdata), .i_wbe(bus.wbe), .o_rdata(bus.rdata_a)
    );

    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd_b (
        .i_mem(r_mem), .i_raddr(bus.raddr_b), .i_wr_ok(w_wr_ok), .i_waddr(bus.waddr),
        .i_wdata(bus.wdata), .i_wbe(bus.wbe), .o_rdata(bus.rdata_b)
    );

    // Debug always observes stored state only.
    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(1'b0)) u_rd_dbg (
        .i_mem(r_mem), .i_raddr(bus.dbg_addr), .i_wr_ok(w_wr_ok), .i_waddr(bus.waddr),
        .i_wdata(bus.wdata), .i_wbe(bus.wbe), .o_rdata(bus.dbg_data)
    );

endmodule
